// File: rtl/mem_stage_ls_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
// Master drives req/we/sel/addr/wdata; slave returns ack and load data.
interface mem_stage_ls_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_sel_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_sel_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_ls.sv
// MEM stage: byte/half/word loads and stores over a variable-latency bus.
// Ports: clk/rst, EX/MEM inputs (*_i), stall_o, mem bus (master), MEM/WB + exc outputs.
module mem_stage_ls #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [3:0]            ls_op_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           store_data_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  stall_o,
  mem_stage_ls_if.master        mem,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_waddr_o,
  output logic                  wb_we_o,
  output logic [31:0]           wb_wdata_o,
  output logic                  exc_misalign_o,
  output logic                  exc_buserr_o,
  output logic [ADDR_W-1:0]     exc_badaddr_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic { IDLE, BUSY } state_e;
  typedef enum logic [1:0] { SZ_N, SZ_B, SZ_H, SZ_W } sz_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic                  ld;
    logic                  sgn;
    sz_e                   sz;
    logic [REG_ADDR_W-1:0] waddr;
    logic                  we;
    logic [31:0]           wdata;
  } cap_t;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cap_t cap_q, cap_d;

  logic req_q, req_d, we_q, we_d;
  logic [3:0] sel_q, sel_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0] mwd_q, mwd_d;

  logic wbv_q, wbv_d, wbwe_q, wbwe_d;
  logic [REG_ADDR_W-1:0] wba_q, wba_d;
  logic [31:0] wbd_q, wbd_d;
  logic mis_q, mis_d, bus_q, bus_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic is_ld, is_st, sgn, mis, mem_op, tmo, accept;
  sz_e sz;
  logic [1:0] lane;
  logic [3:0] sel_c;
  logic [31:0] wd_c, rsh, ld_data;

  // Op decode; unlisted encodings behave as "none".
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sgn   = 1'b0;
    sz    = SZ_N;
    case (ls_op_i)
      4'd1:  begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_B; end
      4'd2:  begin is_ld = 1'b1; sz = SZ_B; end
      4'd3:  begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_H; end
      4'd4:  begin is_ld = 1'b1; sz = SZ_H; end
      4'd5:  begin is_ld = 1'b1; sz = SZ_W; end
      4'd9:  begin is_st = 1'b1; sz = SZ_B; end
      4'd10: begin is_st = 1'b1; sz = SZ_H; end
      4'd11: begin is_st = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

  assign lane   = addr_i[1:0];
  assign mem_op = is_ld | is_st;
  assign mis    = ((sz == SZ_H) && lane[0]) ||
                  ((sz == SZ_W) && (lane != 2'b00));
  assign accept = (state_q == IDLE) && valid_i;

  always_comb begin
    sel_c = 4'b0000;
    wd_c  = store_data_i;
    unique case (sz)
      SZ_B: begin
        sel_c = 4'b0001 << lane;
        wd_c  = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        sel_c = 4'b0011 << lane;
        wd_c  = {2{store_data_i[15:0]}};
      end
      SZ_W: sel_c = 4'b1111;
      default: ;
    endcase
  end

  // Load extraction uses the lane captured at accept time.
  assign rsh = mem.mem_rdata_i >> {cap_q.addr[1:0], 3'b000};

  always_comb begin
    ld_data = mem.mem_rdata_i;
    unique case (cap_q.sz)
      SZ_B: ld_data = {{24{cap_q.sgn & rsh[7]}}, rsh[7:0]};
      SZ_H: ld_data = {{16{cap_q.sgn & rsh[15]}}, rsh[15:0]};
      default: ;
    endcase
  end

  // Ack on the final count still completes the access normally.
  assign tmo = (TIMEOUT_CYC != 0) &&
               (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: if (accept && mem_op && !mis) state_d = BUSY;
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_ack_i || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = 1'b0;
    we_d    = 1'b0;
    sel_d   = '0;
    maddr_d = '0;
    mwd_d   = '0;
    wbv_d   = 1'b0;
    wba_d   = '0;
    wbwe_d  = 1'b0;
    wbd_d   = '0;
    mis_d   = 1'b0;
    bus_d   = 1'b0;
    bad_d   = '0;
    cap_d   = cap_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (!mem_op) begin
          wbv_d  = 1'b1;
          wba_d  = reg_waddr_i;
          wbwe_d = reg_we_i;
          wbd_d  = reg_wdata_i;
        end else if (mis) begin
          wbv_d = 1'b1;
          wba_d = reg_waddr_i;
          mis_d = 1'b1;
          bad_d = addr_i;
        end else begin
          req_d       = 1'b1;
          we_d        = is_st;
          sel_d       = sel_c;
          maddr_d     = {addr_i[ADDR_W-1:2], 2'b00};
          mwd_d       = is_st ? wd_c : 32'h0;
          cap_d.addr  = addr_i;
          cap_d.ld    = is_ld;
          cap_d.sgn   = sgn;
          cap_d.sz    = sz;
          cap_d.waddr = reg_waddr_i;
          cap_d.we    = reg_we_i;
          cap_d.wdata = reg_wdata_i;
        end
      end
      BUSY: begin
        if (mem.mem_ack_i) begin
          wbv_d  = 1'b1;
          wba_d  = cap_q.waddr;
          wbwe_d = cap_q.we;
          wbd_d  = cap_q.ld ? ld_data : cap_q.wdata;
        end else if (tmo) begin
          wbv_d = 1'b1;
          wba_d = cap_q.waddr;
          bus_d = 1'b1;
          bad_d = cap_q.addr;
        end else begin
          req_d   = req_q;
          we_d    = we_q;
          sel_d   = sel_q;
          maddr_d = maddr_q;
          mwd_d   = mwd_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      maddr_q <= '0;
      mwd_q   <= '0;
      wbv_q   <= 1'b0;
      wba_q   <= '0;
      wbwe_q  <= 1'b0;
      wbd_q   <= '0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
      bad_q   <= '0;
      cap_q   <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      wbv_q   <= wbv_d;
      wba_q   <= wba_d;
      wbwe_q  <= wbwe_d;
      wbd_q   <= wbd_d;
      mis_q   <= mis_d;
      bus_q   <= bus_d;
      bad_q   <= bad_d;
      cap_q   <= cap_d;
    end
  end

  assign stall_o         = (state_q == BUSY);
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_sel_o   = sel_q;
  assign mem.mem_addr_o  = maddr_q;
  assign mem.mem_wdata_o = mwd_q;
  assign wb_valid_o      = wbv_q;
  assign wb_waddr_o      = wba_q;
  assign wb_we_o         = wbwe_q;
  assign wb_wdata_o      = wbd_q;
  assign exc_misalign_o  = mis_q;
  assign exc_buserr_o    = bus_q;
  assign exc_badaddr_o   = bad_q;

endmodule
